// File: rtl/bitmap_pkg.sv
// Shared types and helpers for the bitmap address stream.
//   bmp_mode_t : per-request coordinate handling (clip or single-period wrap)
//   sel_width  : width of the sub-word pixel select for a given pixels-per-word
package bitmap_pkg;

    typedef enum logic {
        BMP_CLIP = 1'b0,
        BMP_WRAP = 1'b1
    } bmp_mode_t;

    // Sub-word select is at least one bit wide so the port always exists.
    function automatic int sel_width(input int ppw);
        return (ppw <= 2) ? 1 : $clog2(ppw);
    endfunction

endpackage

// File: rtl/bitmap_axis_fold.sv
// One axis of the fold/clip stage: folds a signed coordinate s into [0, len)
// and registers the result.
//   clk, rst : clock, asynchronous active-high reset
//   en       : load enable; registers hold when low
//   mode     : BMP_CLIP or BMP_WRAP for this request
//   s, len   : signed coordinate and signed axis length (len > 0)
//   c        : folded coordinate (equals s when out of range)
//   oor      : coordinate lies outside the bitmap on this axis
module bitmap_axis_fold
    import bitmap_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  bmp_mode_t               mode,
    input  logic signed [CORDW-1:0] s,
    input  logic signed [CORDW-1:0] len,
    output logic signed [CORDW-1:0] c,
    output logic                    oor
);

    // Two guard bits so that 2*len and s+len cannot overflow.
    localparam int EW = CORDW + 2;

    logic signed [EW-1:0]    s_ext;
    logic signed [EW-1:0]    len_ext;
    logic signed [EW-1:0]    len2_ext;
    logic signed [CORDW-1:0] c_next;
    logic                    oor_next;

    always_comb begin
        s_ext    = EW'(s);
        len_ext  = EW'(len);
        len2_ext = len_ext <<< 1;
        c_next   = s;
        oor_next = 1'b1;
        if (s_ext >= 0 && s_ext < len_ext) begin
            oor_next = 1'b0;
        end else if (mode == BMP_WRAP && s_ext >= -len_ext && s_ext < 0) begin
            c_next   = CORDW'(s_ext + len_ext);
            oor_next = 1'b0;
        end else if (mode == BMP_WRAP && s_ext >= len_ext && s_ext < len2_ext) begin
            c_next   = CORDW'(s_ext - len_ext);
            oor_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c   <= '0;
            oor <= 1'b0;
        end else if (en) begin
            c   <= c_next;
            oor <= oor_next;
        end
    end

endmodule

// File: rtl/bitmap_addr_stream.sv
// Pipelined pixel-coordinate to memory-address translator.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : request handshake
//   mode, base        : clip/wrap mode and bitmap base (in pixels), per request
//   bmpw, bmph        : signed bitmap width and height (> 0)
//   x, y, offx, offy  : signed pixel coordinate and offsets
//   out_valid/out_ready : result handshake
//   addr, sel, clip   : word address, pixel within word, suppress-write flag
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// stage loads when it is empty or the stage after it loads; the output stage
// loads when !out_valid || out_ready. in_ready is the first stage's load
// enable, so it follows out_ready combinationally through one ready chain.
// A holding stage keeps all of its registers unchanged.
module bitmap_addr_stream
    import bitmap_pkg::*;
#(
    parameter  int CORDW = 16,
    parameter  int ADDRW = 24,
    parameter  int PPW   = 1,
    localparam int SELW  = sel_width(PPW)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  bmp_mode_t               mode,
    input  logic [ADDRW-1:0]        base,
    input  logic signed [CORDW-1:0] bmpw,
    input  logic signed [CORDW-1:0] bmph,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic signed [CORDW-1:0] offx,
    input  logic signed [CORDW-1:0] offy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRW-1:0]        addr,
    output logic [SELW-1:0]         sel,
    output logic                    clip
);

    localparam int SHIFT = $clog2(PPW);
    localparam int PW    = 2 * CORDW;

    logic load1, load2, load3;

    // Stage 1: offset addition and request capture
    logic                    s1_valid;
    logic signed [CORDW-1:0] s1_xs, s1_ys;
    bmp_mode_t               s1_mode;
    logic [ADDRW-1:0]        s1_base;
    logic signed [CORDW-1:0] s1_bmpw, s1_bmph;

    // Stage 2: folded coordinates
    logic                    s2_valid;
    logic signed [CORDW-1:0] s2_cx, s2_cy;
    logic                    s2_fx, s2_fy;
    logic [ADDRW-1:0]        s2_base;
    logic signed [CORDW-1:0] s2_bmpw;

    // Stage 3 combinational multiply-add
    logic signed [PW-1:0]    prod;
    logic [ADDRW-1:0]        lin;
    logic [SELW-1:0]         sel_next;

    assign load3    = !out_valid || out_ready;
    assign load2    = !s2_valid || load3;
    assign load1    = !s1_valid || load2;
    assign in_ready = load1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_xs    <= '0;
            s1_ys    <= '0;
            s1_mode  <= BMP_CLIP;
            s1_base  <= '0;
            s1_bmpw  <= '0;
            s1_bmph  <= '0;
        end else if (load1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                // CORDW-bit sums: overflow wraps around by design.
                s1_xs   <= x + offx;
                s1_ys   <= y + offy;
                s1_mode <= mode;
                s1_base <= base;
                s1_bmpw <= bmpw;
                s1_bmph <= bmph;
            end
        end
    end

    bitmap_axis_fold #(.CORDW(CORDW)) u_fold_x (
        .clk  (clk),
        .rst  (rst),
        .en   (load2 && s1_valid),
        .mode (s1_mode),
        .s    (s1_xs),
        .len  (s1_bmpw),
        .c    (s2_cx),
        .oor  (s2_fx)
    );

    bitmap_axis_fold #(.CORDW(CORDW)) u_fold_y (
        .clk  (clk),
        .rst  (rst),
        .en   (load2 && s1_valid),
        .mode (s1_mode),
        .s    (s1_ys),
        .len  (s1_bmph),
        .c    (s2_cy),
        .oor  (s2_fy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_base  <= '0;
            s2_bmpw  <= '0;
        end else if (load2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_base <= s1_base;
                s2_bmpw <= s1_bmpw;
            end
        end
    end

    // Product at full 2*CORDW width; the size casts sign-extend or truncate
    // to ADDRW so the sum wraps modulo 2^ADDRW.
    always_comb begin
        prod = s2_cy * s2_bmpw;
        lin  = s2_base + ADDRW'(prod) + ADDRW'(s2_cx);
        if (PPW == 1) begin
            sel_next = '0;
        end else begin
            sel_next = lin[SELW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            addr      <= '0;
            sel       <= '0;
            clip      <= 1'b0;
        end else if (load3) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                addr <= lin >> SHIFT;
                sel  <= sel_next;
                clip <= s2_fx | s2_fy;
            end
        end
    end

endmodule

// File: tb/tb_bitmap_addr_stream.sv
// Directed bench for bitmap_addr_stream: a PPW=4 instance for most scenarios
// and a PPW=1 instance for the large-bitmap case. Expected results are pushed
// when a request is accepted and popped when the matching result is handed off.
module tb_bitmap_addr_stream;
    import bitmap_pkg::*;

    // Entry: [44:29] accept cycle, [28] check latency, [27] check addr/sel,
    //        [26] clip, [25:24] sel, [23:0] addr
    localparam int EW = 45;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // PPW=4 instance
    logic               in_valid = 1'b0;
    logic               in_ready;
    bmp_mode_t          mode = BMP_CLIP;
    logic [23:0]        base = '0;
    logic signed [15:0] bmpw = 16'sd320;
    logic signed [15:0] bmph = 16'sd180;
    logic signed [15:0] x = '0, y = '0, offx = '0, offy = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [23:0]        addr;
    logic [1:0]         sel;
    logic               clip;

    // PPW=1 instance
    logic               in_valid1 = 1'b0;
    logic               in_ready1;
    bmp_mode_t          mode1 = BMP_CLIP;
    logic [23:0]        base1 = 24'h1000;
    logic signed [15:0] bmpw1 = 16'sd640;
    logic signed [15:0] bmph1 = 16'sd480;
    logic signed [15:0] x1 = '0, y1 = '0, offx1 = '0, offy1 = '0;
    logic               out_valid1;
    logic               out_ready1 = 1'b1;
    logic [23:0]        addr1;
    logic [0:0]         sel1;
    logic               clip1;

    bitmap_addr_stream #(.CORDW(16), .ADDRW(24), .PPW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .base(base), .bmpw(bmpw), .bmph(bmph),
        .x(x), .y(y), .offx(offx), .offy(offy),
        .out_valid(out_valid), .out_ready(out_ready),
        .addr(addr), .sel(sel), .clip(clip)
    );

    bitmap_addr_stream #(.CORDW(16), .ADDRW(24), .PPW(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .mode(mode1), .base(base1), .bmpw(bmpw1), .bmph(bmph1),
        .x(x1), .y(y1), .offx(offx1), .offy(offy1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .addr(addr1), .sel(sel1), .clip(clip1)
    );

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp1_q[$];
    logic [EW-1:0] pending  = '0;
    logic [EW-1:0] pending1 = '0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            cyc0 = 0;
    logic          stall_en = 1'b0;
    logic          accepted = 1'b0;
    logic          prev_hold = 1'b0;
    logic [23:0]   prev_addr = '0;
    logic [1:0]    prev_sel = '0;
    logic          prev_clip = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic void fold(input int s, input int len, input bit wrap,
                                 output int c, output bit f);
        c = s;
        f = 1'b1;
        if (s >= 0 && s < len) f = 1'b0;
        else if (wrap && s < 0 && s >= -len) begin c = s + len; f = 1'b0; end
        else if (wrap && s >= len && s < 2 * len) begin c = s - len; f = 1'b0; end
    endfunction

    function automatic logic [EW-1:0] model(input bmp_mode_t m, input int b, input int w,
                                            input int h, input int xv, input int yv,
                                            input int ox, input int oy, input int ppw);
        logic signed [15:0] xs16, ys16;
        int cx, cy;
        bit fx, fy;
        longint lv;
        logic [EW-1:0] e;
        xs16 = 16'(xv + ox);
        ys16 = 16'(yv + oy);
        fold(int'(xs16), w, m == BMP_WRAP, cx, fx);
        fold(int'(ys16), h, m == BMP_WRAP, cy, fy);
        lv = (longint'(b) + longint'(cy) * longint'(w) + longint'(cx)) & 64'hFF_FFFF;
        e = '0;
        e[23:0]  = 24'(lv / ppw);
        e[25:24] = 2'(lv % ppw);
        e[26]    = fx | fy;
        e[27]    = !(fx | fy);
        return e;
    endfunction

    function automatic logic [EW-1:0] lit(input logic [23:0] a, input logic [1:0] s,
                                          input logic c, input logic chk_addr);
        logic [EW-1:0] e;
        e = '0;
        e[23:0]  = a;
        e[25:24] = s;
        e[26]    = c;
        e[27]    = chk_addr;
        e[28]    = 1'b1;
        return e;
    endfunction

    // One clock cycle: observe both handshakes at the negedge, then advance.
    task automatic tick();
        logic [EW-1:0] e;
        int rel;
        rel = cyc - cyc0;
        out_ready = !(stall_en && rel >= 5 && rel <= 7);
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = pending;
            e[44:29] = 16'(cyc);
            exp_q.push_back(e);
        end
        if (in_valid && out_ready) chk("in_ready_chain", in_ready, 1);
        if (stall_en && rel >= 5 && rel <= 7 && in_valid) chk("in_ready_full", in_ready, 0);
        if (prev_hold) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_addr", addr, prev_addr);
            chk("stall_sel", sel, prev_sel);
            chk("stall_clip", clip, prev_clip);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("clip", clip, e[26]);
                if (e[27]) begin
                    chk("addr", addr, e[23:0]);
                    chk("sel", sel, e[25:24]);
                end
                if (e[28]) chk("latency", 32'(cyc - int'(e[44:29])), 3);
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_addr = addr;
        prev_sel  = sel;
        prev_clip = clip;
        if (in_valid1 && in_ready1) begin
            e = pending1;
            e[44:29] = 16'(cyc);
            exp1_q.push_back(e);
        end
        if (out_valid1) begin
            if (exp1_q.size() == 0) begin
                chk("spurious_out1", out_valid1, 0);
            end else begin
                e = exp1_q.pop_front();
                chk("clip1", clip1, e[26]);
                chk("addr1", addr1, e[23:0]);
                chk("sel1", sel1, e[24]);
                chk("latency1", 32'(cyc - int'(e[44:29])), 3);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present one request and hold it until accepted; in_valid stays high.
    task automatic send(input bmp_mode_t m, input logic [23:0] b, input int xv, input int yv,
                        input int ox, input int oy, input logic [EW-1:0] e);
        int n;
        mode = m; base = b; x = 16'(xv); y = 16'(yv); offx = 16'(ox); offy = 16'(oy);
        pending  = e;
        in_valid = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            tick();
            n++;
        end
        if (!accepted) chk("accept_timeout", accepted, 1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size() + exp1_q.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_sel", sel, 0);
        chk("rst_clip", clip, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        // directed vectors, one at a time
        send(BMP_CLIP, 24'd0, 10, 2, 0, 0, lit(24'd162, 2'd2, 1'b0, 1'b1));      drain();
        send(BMP_WRAP, 24'd0, -1, 0, 0, 0, lit(24'd79, 2'd3, 1'b0, 1'b1));       drain();
        send(BMP_CLIP, 24'd0, -1, 0, 0, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));        drain();
        send(BMP_WRAP, 24'd0, 5, 185, 0, 0, lit(24'd401, 2'd1, 1'b0, 1'b1));     drain();
        send(BMP_WRAP, 24'd0, 700, 0, 0, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));       drain();
        send(BMP_CLIP, 24'd0, 10, 0, -20, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));      drain();
        send(BMP_CLIP, 24'd0, 32767, 0, 1, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));     drain();
        send(BMP_WRAP, 24'd0, 32767, 0, 1, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));     drain();
        // wrap boundaries on x: L-1, L, 2L-1, 2L, -L, -L-1
        send(BMP_WRAP, 24'd0, 319, 0, 0, 0, lit(24'd79, 2'd3, 1'b0, 1'b1));      drain();
        send(BMP_WRAP, 24'd0, 320, 0, 0, 0, lit(24'd0, 2'd0, 1'b0, 1'b1));       drain();
        send(BMP_WRAP, 24'd0, 639, 0, 0, 0, lit(24'd79, 2'd3, 1'b0, 1'b1));      drain();
        send(BMP_WRAP, 24'd0, 640, 0, 0, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));       drain();
        send(BMP_WRAP, 24'd0, -320, 0, 0, 0, lit(24'd0, 2'd0, 1'b0, 1'b1));      drain();
        send(BMP_WRAP, 24'd0, -321, 0, 0, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));      drain();
        send(BMP_CLIP, 24'd0, 320, 0, 0, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));       drain();
        send(BMP_CLIP, 24'd0, 0, 180, 0, 0, lit(24'd0, 2'd0, 1'b1, 1'b0));       drain();
        // offsets on both axes, and base wrap-around modulo 2^24
        send(BMP_CLIP, 24'd0, 3, 1, 4, 1, lit(24'd161, 2'd3, 1'b0, 1'b1));       drain();
        send(BMP_CLIP, 24'hFFFFFF, 1, 0, 0, 0, lit(24'd0, 2'd0, 1'b0, 1'b1));    drain();
        send(BMP_CLIP, 24'd100, 0, 0, 0, 0, lit(24'd25, 2'd0, 1'b0, 1'b1));      drain();

        // PPW=1, large bitmap with non-zero base
        x1 = 16'sd639;
        y1 = 16'sd479;
        pending1  = lit(24'd311295, 2'd0, 1'b0, 1'b1);
        in_valid1 = 1'b1;
        tick();
        drain();

        // 16 back-to-back requests, out_ready low for stream cycles 5-7
        stall_en = 1'b1;
        cyc0 = cyc;
        for (int i = 0; i < 16; i++) begin
            bmp_mode_t m;
            int xv, yv, ox, oy;
            m  = bmp_mode_t'($urandom_range(0, 1));
            xv = int'($urandom_range(0, 900)) - 300;
            yv = int'($urandom_range(0, 500)) - 150;
            ox = int'($urandom_range(0, 40)) - 20;
            oy = int'($urandom_range(0, 40)) - 20;
            send(m, 24'd64, xv, yv, ox, oy, model(m, 64, 320, 180, xv, yv, ox, oy, 4));
        end
        drain();
        stall_en = 1'b0;

        // asynchronous reset with three requests in flight
        send(BMP_CLIP, 24'd0, 1, 0, 0, 0, lit(24'd0, 2'd1, 1'b0, 1'b1));
        send(BMP_CLIP, 24'd0, 2, 0, 0, 0, lit(24'd0, 2'd2, 1'b0, 1'b1));
        send(BMP_CLIP, 24'd0, 3, 0, 0, 0, lit(24'd0, 2'd3, 1'b0, 1'b1));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        exp_q.delete();
        prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        repeat (5) tick();
        send(BMP_CLIP, 24'd0, 10, 2, 0, 0, lit(24'd162, 2'd2, 1'b0, 1'b1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
